spi_motion_sensor_responder: RTL and testbench
==============================================

SPI_MOTION_SENSOR_RESPONDER -- requirements
Module: spi_motion_sensor_responder

Interface
REQ-001 SHALL have parameter MOTION_THRESH, default 16'sh0100, signed magnitude threshold for motion_int.
REQ-002 SHALL have parameter DEVICE_ID, default 16'h00E5, value returned for register 0x00.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), at most clk/8.
REQ-006 mosi  input  1  SPI data from master, MSB first.
REQ-007 cs_n  input  1  SPI chip select, active-low, frames 16 bits.
REQ-008 miso  output  1  SPI data to master; driven 0 when cs_n high (no tristate).
REQ-009 x_axis_in / y_axis_in  input  16 each  signed two's-complement axis samples.
REQ-010 sample_valid  input  1  one-cycle strobe; x/y inputs valid.
REQ-011 motion_int  output  1  latched motion interrupt.
REQ-012 frame_error  output  1  one-cycle pulse on malformed frame.
REQ-013 frame_count  output  16  count of good frames, wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL pass sclk, mosi, cs_n through 2-FF synchronizers; edges detected on synchronized sclk.
REQ-015 SHALL sample mosi on synchronized sclk rising edge; shift miso on falling edge; first bit presented within 1 clk of synchronized cs_n falling.
REQ-016 Command word: bit15=1 read, bit15=0 write; bits[7:0] register address; bits[14:8] ignored.
REQ-017 Reads pipelined: data shifted out in frame N = response to read command of frame N-1; response register loaded into tx shifter at cs_n fall.
REQ-018 Register map: 0x00->DEVICE_ID, 0x32->x shadow, 0x34->y shadow, any other address->0x0000.
REQ-019 Write frames and reads of unmapped addresses SHALL count as good frames; writes load response register with 0x0000.
REQ-020 Good frame = exactly 16 rising sclk edges between cs_n fall and rise; on cs_n rise SHALL decode, update response register, increment frame_count.
REQ-021 cs_n rise with bit count != 16 (including >16) SHALL pulse frame_error 1 clk, discard frame, leave response register and frame_count unchanged.
REQ-022 On sample_valid, x/y shadow registers SHALL capture inputs next clk; response register holds the value decoded at frame end (no tearing mid-frame).
REQ-023 motion_int SHALL set 1 clk after sample_valid when |x|>MOTION_THRESH or |y|>MOTION_THRESH (signed compare; -32768 treated as exceeding).
REQ-024 motion_int SHALL clear on completion of a good read frame to 0x32; simultaneous set and clear -> set wins.
REQ-025 Transitions: IDLE -(cs_n fall)-> SHIFT -(cs_n rise)-> DECODE (1 clk) -> IDLE; cs_n fall in DECODE is held until IDLE.

Reset
REQ-026 rst_n low SHALL force miso=0, motion_int=0, frame_error=0, frame_count=0, shadows=0, response register=0x0000, state IDLE.
REQ-027 Reset mid-frame SHALL abandon the frame; remaining sclk edges before next cs_n fall SHALL be ignored.

Structure
REQ-028 Register addresses (0x00, 0x32, 0x34) and read-bit position SHALL live in iot_sensor_pkg, shared with the master side.
REQ-029 Synchronizer, bit counter and shift registers SHALL be sub-module spi_slave; decode, shadows, interrupt in the top.

Verification
REQ-030 Frame 0x8000 then 0x0000 -> second frame miso returns 0x00E5; frame_count=2.
REQ-031 sample_valid x=0x0200,y=0x0010 -> motion_int=1 next clk; frames 0x8032,0x8034,0x0000 -> returns 0x0200 then 0x0010; motion_int clears after first frame.
REQ-032 sample x=0xFE00 (-512) -> motion_int=1; x=0x0100,y=0xFF00 -> motion_int stays 0 (not exceeding).
REQ-033 cs_n raised after 9 bits -> frame_error pulse, frame_count unchanged, next frame still returns previous response.
REQ-034 rst_n asserted after 5 bits of a 0x8032 frame -> all outputs reset; following 0x8000 frame returns 0x0000.
REQ-035 sample_valid exceeding threshold on same clk as clearing 0x8032 frame end -> motion_int remains 1.

Source files
------------

// File: rtl/iot_sensor_pkg.sv
// Shared definitions for the motion-sensor SPI link: register map, command
// layout, responder FSM states and the axis threshold helper.
package iot_sensor_pkg;

    localparam int FRAME_BITS = 16;
    localparam int READ_BIT   = 15;

    localparam logic [7:0] ADDR_DEVICE_ID = 8'h00;
    localparam logic [7:0] ADDR_X_AXIS    = 8'h32;
    localparam logic [7:0] ADDR_Y_AXIS    = 8'h34;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DECODE
    } spi_state_e;

    // A 17-bit magnitude lets -32768 become +32768, which exceeds any threshold.
    function automatic logic exceeds_thresh(input logic signed [15:0] sample,
                                            input logic signed [15:0] thresh);
        logic signed [16:0] mag;
        mag = sample[15] ? -17'(sample) : 17'(sample);
        return mag > 17'(thresh);
    endfunction

endpackage

// File: rtl/spi_motion_sensor_responder_if.sv
// SPI bus between a master and the motion-sensor responder.
interface spi_motion_sensor_responder_if;

    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;

    modport master (output sclk, mosi, cs_n, input miso);
    modport slave  (input sclk, mosi, cs_n, output miso);

endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI slave front end: input synchronizers, frame FSM, bit counter
// and the rx/tx shift registers. Reports each finished frame as good or bad.
module spi_slave
    import iot_sensor_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    input  logic [15:0] tx_word,
    output logic        miso,
    output logic        cmd_read,
    output logic [7:0]  cmd_addr,
    output logic        frame_good,
    output logic        frame_bad
);

    logic [2:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [2:0] cs_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            // NOTE: the chip-select chain resets to "selected" so a frame still in
            // flight at reset release never looks like a fresh cs_n fall.
            cs_sync   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every stage sampling the
            // previous-cycle value, which is what makes this a shift chain.
            sclk_sync <= {sclk_sync[1:0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_sync   <= {cs_sync[1:0], cs_n};
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = cs_sync[2] & ~cs_sync[1];
    assign cs_rise   = ~cs_sync[2] & cs_sync[1];

    spi_state_e  state;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_shift;
    logic [15:0] tx_shift;
    logic        fall_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            fall_pending <= 1'b0;
            frame_good   <= 1'b0;
            frame_bad    <= 1'b0;
        end else begin
            frame_good <= 1'b0;
            frame_bad  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall || fall_pending) begin
                        state        <= ST_SHIFT;
                        bit_cnt      <= '0;
                        tx_shift     <= tx_word;
                        fall_pending <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state      <= ST_DECODE;
                        frame_good <= (bit_cnt == 5'(FRAME_BITS));
                        frame_bad  <= (bit_cnt != 5'(FRAME_BITS));
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[14:0], mosi_sync[1]};
                            // Saturate so overlong frames stay distinguishable from 16.
                            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (sclk_fall) tx_shift <= {tx_shift[14:0], 1'b0};
                    end
                end
                ST_DECODE: begin
                    state        <= ST_IDLE;
                    fall_pending <= cs_fall;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign miso     = (state == ST_SHIFT) & tx_shift[15];
    assign cmd_read = rx_shift[READ_BIT];
    assign cmd_addr = rx_shift[7:0];

endmodule

// File: rtl/spi_motion_sensor_responder.sv
// Motion-sensor SPI responder: axis shadow registers, pipelined register
// reads, good-frame counter and a latched motion interrupt.
module spi_motion_sensor_responder
    import iot_sensor_pkg::*;
#(
    parameter logic signed [15:0] MOTION_THRESH = 16'sh0100,
    parameter logic [15:0]        DEVICE_ID     = 16'h00E5
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_motion_sensor_responder_if.slave spi,
    input  logic signed [15:0]  x_axis_in,
    input  logic signed [15:0]  y_axis_in,
    input  logic                sample_valid,
    output logic                motion_int,
    output logic                frame_error,
    output logic [15:0]         frame_count
);

    logic [15:0] resp_reg;
    logic [15:0] x_shadow;
    logic [15:0] y_shadow;
    logic        cmd_read;
    logic [7:0]  cmd_addr;
    logic        frame_good;
    logic        frame_bad;
    logic        miso_int;

    spi_slave u_spi_slave (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (spi.sclk),
        .mosi       (spi.mosi),
        .cs_n       (spi.cs_n),
        .tx_word    (resp_reg),
        .miso       (miso_int),
        .cmd_read   (cmd_read),
        .cmd_addr   (cmd_addr),
        .frame_good (frame_good),
        .frame_bad  (frame_bad)
    );

    assign spi.miso    = miso_int;
    assign frame_error = frame_bad;

    logic [15:0] read_data;

    always_comb begin
        // NOTE: default first so every path assigns read_data and no latch is inferred.
        read_data = '0;
        if (cmd_read) begin
            case (cmd_addr)
                ADDR_DEVICE_ID: read_data = DEVICE_ID;
                ADDR_X_AXIS:    read_data = x_shadow;
                ADDR_Y_AXIS:    read_data = y_shadow;
                default:        read_data = '0;
            endcase
        end
    end

    logic motion_hit, motion_clear;
    assign motion_hit   = sample_valid &&
                          (exceeds_thresh(x_axis_in, MOTION_THRESH) ||
                           exceeds_thresh(y_axis_in, MOTION_THRESH));
    assign motion_clear = frame_good && cmd_read && (cmd_addr == ADDR_X_AXIS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_shadow    <= '0;
            y_shadow    <= '0;
            motion_int  <= 1'b0;
            resp_reg    <= '0;
            frame_count <= '0;
        end else begin
            if (sample_valid) begin
                x_shadow <= x_axis_in;
                y_shadow <= y_axis_in;
            end
            // A new event outranks the acknowledge so no motion is ever lost.
            if (motion_hit)        motion_int <= 1'b1;
            else if (motion_clear) motion_int <= 1'b0;
            // The response only changes at frame end, so the tx shifter never tears.
            if (frame_good) begin
                resp_reg    <= read_data;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_motion_sensor_responder.sv
// Directed bench for spi_motion_sensor_responder: acts as SPI master and
// axis sample source, checking hand-computed responses and flags.
module tb_spi_motion_sensor_responder;

    localparam int HALF = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] x_axis_in;
    logic signed [15:0] y_axis_in;
    logic               sample_valid;
    logic               motion_int;
    logic               frame_error;
    logic [15:0]        frame_count;

    int checks     = 0;
    int failures   = 0;
    int err_pulses = 0;

    spi_motion_sensor_responder_if spi ();

    spi_motion_sensor_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi          (spi),
        .x_axis_in    (x_axis_in),
        .y_axis_in    (y_axis_in),
        .sample_valid (sample_valid),
        .motion_int   (motion_int),
        .frame_error  (frame_error),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_error === 1'b1) err_pulses++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y);
        x_axis_in    = x;
        y_axis_in    = y;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    // Clocks nbits out with cs_n held low; returns the first 16 miso bits.
    task automatic spi_shift(input logic [15:0] word, input int nbits, output logic [15:0] rx);
        logic [15:0] tx;
        tx = word;
        rx = '0;
        spi.cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = tx[15];
            tx = {tx[14:0], 1'b0};
            tick(HALF);
            if (i < 16) rx = {rx[14:0], spi.miso};
            spi.sclk = 1'b1;
            tick(HALF);
            spi.sclk = 1'b0;
        end
        tick(HALF);
    endtask

    task automatic spi_end();
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        tick(12);
    endtask

    task automatic spi_xfer(input logic [15:0] word, output logic [15:0] rx);
        spi_shift(word, 16, rx);
        spi_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi.cs_n = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
        sample_valid = 1'b0; x_axis_in = '0; y_axis_in = '0;
        tick(3);
        checks++; if (spi.miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", spi.miso); end
        checks++; if (motion_int !== 1'b0) begin failures++; $display("FAIL reset_motion_int: got %b expected 0", motion_int); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
        checks++; if (frame_count !== 16'h0000) begin failures++; $display("FAIL reset_frame_count: got %h expected 0000", frame_count); end
        rst_n = 1'b1;
        tick(4);
        checks++; if (spi.miso !== 1'b0) begin failures++; $display("FAIL idle_miso: got %b expected 0", spi.miso); end
    endtask

    task automatic test_device_id();
        logic [15:0] rx;
        spi_xfer(16'h8000, rx);
        checks++; if (rx !== 16'h0000) begin failures++; $display("FAIL first_frame_resp: got %h expected 0000", rx); end
        spi_xfer(16'h0000, rx);
        checks++; if (rx !== 16'h00E5) begin failures++; $display("FAIL device_id: got %h expected 00e5", rx); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL dev_frame_count: got %0d expected 2", frame_count); end
    endtask

    task automatic test_shadow_read();
        logic [15:0] rx;
        pulse_sample(16'h0200, 16'h0010);
        checks++; if (motion_int !== 1'b1) begin failures++; $display("FAIL motion_set: got %b expected 1", motion_int); end
        spi_xfer(16'h8032, rx);
        checks++; if (rx !== 16'h0000) begin failures++; $display("FAIL shadow_prev_write: got %h expected 0000", rx); end
        checks++; if (motion_int !== 1'b0) begin failures++; $display("FAIL motion_clear_x_read: got %b expected 0", motion_int); end
        spi_xfer(16'h8034, rx);
        checks++; if (rx !== 16'h0200) begin failures++; $display("FAIL x_shadow: got %h expected 0200", rx); end
        spi_xfer(16'h0000, rx);
        checks++; if (rx !== 16'h0010) begin failures++; $display("FAIL y_shadow: got %h expected 0010", rx); end
        checks++; if (frame_count !== 16'd5) begin failures++; $display("FAIL shadow_frame_count: got %0d expected 5", frame_count); end
    endtask

    task automatic test_threshold();
        logic [15:0] rx;
        pulse_sample(16'hFE00, 16'h0000);
        checks++; if (motion_int !== 1'b1) begin failures++; $display("FAIL neg_x_exceeds: got %b expected 1", motion_int); end
        spi_xfer(16'h8032, rx);
        checks++; if (rx !== 16'h0000) begin failures++; $display("FAIL thr_prev_write: got %h expected 0000", rx); end
        checks++; if (motion_int !== 1'b0) begin failures++; $display("FAIL thr_clear: got %b expected 0", motion_int); end
        pulse_sample(16'h0100, 16'hFF00);
        checks++; if (motion_int !== 1'b0) begin failures++; $display("FAIL at_threshold: got %b expected 0", motion_int); end
        pulse_sample(16'h8000, 16'h0000);
        checks++; if (motion_int !== 1'b1) begin failures++; $display("FAIL most_negative: got %b expected 1", motion_int); end
        spi_xfer(16'h8034, rx);
        checks++; if (rx !== 16'hFE00) begin failures++; $display("FAIL x_neg_shadow: got %h expected fe00", rx); end
        checks++; if (motion_int !== 1'b1) begin failures++; $display("FAIL y_read_no_clear: got %b expected 1", motion_int); end
        spi_xfer(16'h8032, rx);
        checks++; if (rx !== 16'h0000) begin failures++; $display("FAIL y_zero_shadow: got %h expected 0000", rx); end
        checks++; if (motion_int !== 1'b0) begin failures++; $display("FAIL thr_clear2: got %b expected 0", motion_int); end
        spi_xfer(16'h8010, rx);
        checks++; if (rx !== 16'h8000) begin failures++; $display("FAIL x_min_shadow: got %h expected 8000", rx); end
        spi_xfer(16'h0000, rx);
        checks++; if (rx !== 16'h0000) begin failures++; $display("FAIL unmapped_read: got %h expected 0000", rx); end
        spi_xfer(16'hFF00, rx);
        spi_xfer(16'h0000, rx);
        checks++; if (rx !== 16'h00E5) begin failures++; $display("FAIL ignored_bits: got %h expected 00e5", rx); end
        checks++; if (frame_count !== 16'd12) begin failures++; $display("FAIL thr_frame_count: got %0d expected 12", frame_count); end
    endtask

    task automatic test_short_frame();
        logic [15:0] rx;
        int e0;
        spi_xfer(16'h8000, rx);
        e0 = err_pulses;
        spi_shift(16'h8034, 9, rx);
        spi_end();
        checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL short_err_pulse: got %0d cycles expected 1", err_pulses - e0); end
        checks++; if (frame_count !== 16'd13) begin failures++; $display("FAIL short_count: got %0d expected 13", frame_count); end
        spi_xfer(16'h0000, rx);
        checks++; if (rx !== 16'h00E5) begin failures++; $display("FAIL short_keeps_resp: got %h expected 00e5", rx); end
        spi_xfer(16'h8000, rx);
        e0 = err_pulses;
        spi_shift(16'h0000, 17, rx);
        spi_end();
        checks++; if (err_pulses !== e0 + 1) begin failures++; $display("FAIL long_err_pulse: got %0d cycles expected 1", err_pulses - e0); end
        checks++; if (frame_count !== 16'd15) begin failures++; $display("FAIL long_count: got %0d expected 15", frame_count); end
        spi_xfer(16'h0000, rx);
        checks++; if (rx !== 16'h00E5) begin failures++; $display("FAIL long_keeps_resp: got %h expected 00e5", rx); end
    endtask

    task automatic test_set_wins();
        logic [15:0] rx;
        pulse_sample(16'h0200, 16'h0000);
        spi_shift(16'h8032, 16, rx);
        checks++; if (rx !== 16'h0000) begin failures++; $display("FAIL sw_prev_write: got %h expected 0000", rx); end
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        x_axis_in = 16'h0300;
        y_axis_in = 16'h0000;
        sample_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checks++; if (motion_int !== 1'b1) begin failures++; $display("FAIL set_wins_cycle%0d: got %b expected 1", i, motion_int); end
        end
        sample_valid = 1'b0;
        tick(8);
        checks++; if (motion_int !== 1'b1) begin failures++; $display("FAIL set_wins_after: got %b expected 1", motion_int); end
        checks++; if (frame_count !== 16'd17) begin failures++; $display("FAIL sw_count: got %0d expected 17", frame_count); end
        spi_xfer(16'h0000, rx);
        checks++; if (rx !== 16'h0300) begin failures++; $display("FAIL sw_x_shadow: got %h expected 0300", rx); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] rx;
        int e0;
        spi_xfer(16'h8000, rx);
        pulse_sample(16'h0400, 16'h0000);
        spi_shift(16'h8032, 5, rx);
        rst_n = 1'b0;
        tick(2);
        checks++; if (spi.miso !== 1'b0) begin failures++; $display("FAIL mid_rst_miso: got %b expected 0", spi.miso); end
        checks++; if (motion_int !== 1'b0) begin failures++; $display("FAIL mid_rst_motion: got %b expected 0", motion_int); end
        checks++; if (frame_count !== 16'h0000) begin failures++; $display("FAIL mid_rst_count: got %h expected 0000", frame_count); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL mid_rst_error: got %b expected 0", frame_error); end
        rst_n = 1'b1;
        tick(2);
        e0 = err_pulses;
        spi_shift(16'h0000, 11, rx);
        spi_end();
        checks++; if (err_pulses !== e0) begin failures++; $display("FAIL stale_edges_error: got %0d cycles expected 0", err_pulses - e0); end
        checks++; if (frame_count !== 16'h0000) begin failures++; $display("FAIL stale_edges_count: got %h expected 0000", frame_count); end
        spi_xfer(16'h8000, rx);
        checks++; if (rx !== 16'h0000) begin failures++; $display("FAIL post_rst_resp: got %h expected 0000", rx); end
        spi_xfer(16'h8032, rx);
        checks++; if (rx !== 16'h00E5) begin failures++; $display("FAIL post_rst_dev_id: got %h expected 00e5", rx); end
        spi_xfer(16'h0000, rx);
        checks++; if (rx !== 16'h0000) begin failures++; $display("FAIL post_rst_x_shadow: got %h expected 0000", rx); end
        checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL post_rst_count: got %0d expected 3", frame_count); end
    endtask

    initial begin
        test_reset();
        test_device_id();
        test_shadow_read();
        test_threshold();
        test_short_frame();
        test_set_wins();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
